mpp_res_unpack: RTL and testbench

- Upstream neighbour of the MPP reconstruction stage.
- Serially parses one substream's MPP quantized residuals from a packed 32-bit word stream.
- Each residual is fixed-width, MSB-first, two's complement. Each is sign-extended to 8 bits.
- Presents a 16-entry residual vector per block under a valid/ready handshake. Four instances, one per substream (ssm0..ssm3), feed the reconstruction stage's residual arrays.

---
 rtl/mpp_res_unpack.sv | 154 +++++++++++++++
 tb/tb_mpp_res_unpack.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpp_res_unpack.sv
// mpp_res_unpack: serial parser for one substream's MPP quantized residuals.
// Pulls fixed-width two's-complement fields MSB-first out of a packed 32-bit
// word stream and presents them as a sign-extended 16-entry vector.
module mpp_res_unpack #(
    parameter int unsigned NUM_RES = 16,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned IN_W    = 32,
    parameter int unsigned BUF_W   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 res_bits,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NUM_RES*OUT_W-1:0]   out_res,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned CNT_W = $clog2(BUF_W + 1);
    localparam int unsigned IDX_W = $clog2(NUM_RES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [BUF_W-1:0]           acc;
    logic [BUF_W-1:0]           acc_next;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_next;
    logic [3:0]                 w;
    logic [3:0]                 w_next;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_next;
    logic [NUM_RES*OUT_W-1:0]   res_next;
    logic                       valid_next;
    logic                       err_next;

    logic                       accept;
    logic                       extract;
    logic                       legal;
    logic [3:0]                 rsh;
    logic [OUT_W-1:0]           top_bits;
    logic [OUT_W-1:0]           field;
    logic [OUT_W-1:0]           sext;
    logic [BUF_W-1:0]           acc_sh;
    logic [CNT_W-1:0]           cnt_sh;

    // Room for a whole word below the live bits, held off during reset
    assign in_ready = !rst && (cnt <= CNT_W'(IN_W));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign legal    = (res_bits != 4'd0) && (res_bits <= 4'd8);
    assign extract  = (state == UNPACK) && (cnt >= CNT_W'(w));

    // Top w bits of the accumulator, sign-extended from the field MSB
    always_comb begin
        rsh      = 4'(OUT_W) - w;
        top_bits = acc[BUF_W-1 -: OUT_W];
        field    = top_bits >> rsh;
        sext     = top_bits[OUT_W-1] ? (field | ~({OUT_W{1'b1}} >> rsh)) : field;
    end

    // Consume extracted bits, then append an accepted word just below what is left
    always_comb begin
        acc_sh   = extract ? (acc << w) : acc;
        cnt_sh   = extract ? (cnt - CNT_W'(w)) : cnt;
        acc_next = acc_sh;
        cnt_next = cnt_sh;
        if (accept) begin
            acc_next = acc_sh | ({in_data, {(BUF_W-IN_W){1'b0}}} >> cnt_sh);
            cnt_next = cnt_sh + CNT_W'(IN_W);
        end
    end

    // Block sequencing: start/width latch, per-entry writes, output hold
    always_comb begin
        state_next = state;
        w_next     = w;
        idx_next   = idx;
        res_next   = out_res;
        valid_next = out_valid;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        w_next     = res_bits;
                        idx_next   = '0;
                        state_next = UNPACK;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            UNPACK: begin
                if (extract) begin
                    for (int unsigned k = 0; k < NUM_RES; k++) begin
                        if (IDX_W'(k) == idx) begin
                            res_next[k*OUT_W +: OUT_W] = sext;
                        end
                    end
                    idx_next = idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_RES - 1)) begin
                        state_next = HOLD;
                        valid_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            w         <= '0;
            idx       <= '0;
            out_res   <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            w         <= w_next;
            idx       <= idx_next;
            out_res   <= res_next;
            out_valid <= valid_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_mpp_res_unpack.sv
// Bench for mpp_res_unpack: bit-stream model feeding a vector scoreboard,
// a sign-extension table, and directed multi-cycle sequences.
module tb_mpp_res_unpack;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   res_bits = 4'd0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_res;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         err;

    mpp_res_unpack dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .res_bits  (res_bits),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_res   (out_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         w;
        logic [7:0] field;
        logic [7:0] expv;
    } sx_rec_t;

    int           total = 0;
    int           bad = 0;
    logic [31:0]  tx_q[$];
    bit           bits_q[$];
    logic [127:0] exp_q[$];
    int           feed_mode = 0;
    int           tog = 0;
    bit           ordy_v = 1'b1;
    bit           rst_v = 1'b1;
    logic [3:0]   res_v = 4'd0;
    logic         s_valid, s_busy, s_err, s_ready;
    logic [127:0] s_res;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] wd);
        tx_q.push_back(wd);
        for (int i = 31; i >= 0; i--) bits_q.push_back(wd[i]);
    endtask

    // Next 16 fields of width w from the stream, sign-extended by shifting in bits
    function automatic logic [127:0] model_block(input int w);
        logic [127:0] v;
        logic [7:0]   f;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            f = 8'h00;
            for (int b = 0; b < w; b++) f = {f[6:0], bits_q.pop_front()};
            if (f[w-1]) f = f | (8'hFF << w);
            v[k*8 +: 8] = f;
        end
        return v;
    endfunction

    // One clock: drive at negedge, sample 1ns later, retire accepted word at posedge
    task automatic cycle(input bit st);
        bit take;
        @(negedge clk);
        rst       = rst_v;
        out_ready = ordy_v;
        res_bits  = res_v;
        start     = st;
        tog++;
        if (tx_q.size() > 0 && (feed_mode == 1 || (feed_mode == 2 && (tog % 2 == 1)))) begin
            in_valid = 1'b1;
            in_data  = tx_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        #1;
        s_valid = out_valid;
        s_busy  = busy;
        s_err   = err;
        s_ready = in_ready;
        s_res   = out_res;
        take    = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_vector: got %h want none", out_res);
            end else begin
                check("scoreboard", out_res, exp_q.pop_front());
            end
        end
        @(posedge clk);
        if (take) void'(tx_q.pop_front());
    endtask

    task automatic start_block(input int w);
        res_v = 4'(w);
        if (w >= 1 && w <= 8) exp_q.push_back(model_block(w));
        cycle(1'b1);
    endtask

    task automatic wait_valid(input string name, input int maxc, output int lat);
        lat = 0;
        for (int i = 1; i <= maxc; i++) begin
            cycle(1'b0);
            if (s_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL %s: out_valid timeout after %0d cycles want asserted", name, maxc);
        end
    endtask

    initial begin
        sx_rec_t      tbl[13];
        int           lat;
        logic [127:0] v;
        logic [127:0] hold;
        logic [31:0]  wd;
        int           nb;

        tbl[0]  = '{1, 8'h01, 8'hFF};
        tbl[1]  = '{1, 8'h00, 8'h00};
        tbl[2]  = '{2, 8'h02, 8'hFE};
        tbl[3]  = '{2, 8'h01, 8'h01};
        tbl[4]  = '{3, 8'h04, 8'hFC};
        tbl[5]  = '{3, 8'h03, 8'h03};
        tbl[6]  = '{4, 8'h08, 8'hF8};
        tbl[7]  = '{5, 8'h10, 8'hF0};
        tbl[8]  = '{6, 8'h2A, 8'hEA};
        tbl[9]  = '{7, 8'h40, 8'hC0};
        tbl[10] = '{7, 8'h3F, 8'h3F};
        tbl[11] = '{8, 8'h80, 8'h80};
        tbl[12] = '{8, 8'h7F, 8'h7F};

        // Reset state
        rst_v = 1'b1;
        cycle(1'b0);
        cycle(1'b0);
        check("rst_in_ready", s_ready, 0);
        check("rst_out_valid", s_valid, 0);
        check("rst_busy", s_busy, 0);
        check("rst_err", s_err, 0);
        check("rst_out_res", s_res, 0);
        rst_v = 1'b0;
        cycle(1'b0);
        check("post_rst_in_ready", s_ready, 1);

        // Nibble decode with both words prefetched in IDLE
        feed_mode = 1;
        ordy_v = 1'b1;
        push_word(32'h01234567);
        push_word(32'h89ABCDEF);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        start_block(4);
        wait_valid("nibble", 40, lat);
        check("nibble_latency", lat, 17);
        check("nibble_vec", s_res, 128'hFFFEFDFCFBFAF9F8_0706050403020100);
        cycle(1'b0);
        check("nibble_valid_drop", s_valid, 0);
        check("nibble_in_ready", s_ready, 1);

        // Sign-extension table: each record fills two blocks of one repeated field
        foreach (tbl[r]) begin
            nb = 0;
            wd = '0;
            for (int rep = 0; rep < 32; rep++) begin
                for (int b = tbl[r].w - 1; b >= 0; b--) begin
                    wd = {wd[30:0], tbl[r].field[b]};
                    nb++;
                    if (nb == 32) begin
                        push_word(wd);
                        nb = 0;
                    end
                end
            end
            for (int k = 0; k < 16; k++) v[k*8 +: 8] = tbl[r].expv;
            for (int blk = 0; blk < 2; blk++) begin
                start_block(tbl[r].w);
                wait_valid("sext", 60, lat);
                check($sformatf("sext w=%0d f=%h blk=%0d", tbl[r].w, tbl[r].field, blk), s_res, v);
            end
        end

        // Leftover carry, block 1: 48 of 64 bits consumed
        push_word(32'h00000000);
        push_word(32'hFFFFFFFF);
        start_block(3);
        wait_valid("carry1", 60, lat);
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = (k < 10) ? 8'h00 : ((k == 10) ? 8'h01 : 8'hFF);
        check("carry1_vec", s_res, v);

        // Leftover carry, block 2: only the 16 carried bits available at first
        feed_mode = 0;
        push_word(32'h01020304);
        push_word(32'h05060708);
        push_word(32'h090A0B0C);
        push_word(32'h0D0E0F10);
        start_block(8);
        for (int i = 0; i < 4; i++) cycle(1'b0);
        check("carry2_stall_busy", s_busy, 1);
        check("carry2_stall_valid", s_valid, 0);
        check("carry2_partial", s_res[31:0], 32'h0000FFFF);
        feed_mode = 1;
        wait_valid("carry2", 80, lat);
        check("carry2_vec", s_res, 128'h0E0D0C0B0A090807_060504030201FFFF);

        // Backpressure in HOLD with words still arriving
        ordy_v = 1'b0;
        push_word(32'h11223344);
        push_word(32'h55667788);
        push_word(32'h99AABBCC);
        push_word(32'hDDEEFF00);
        push_word(32'hC0C1C2C3);
        push_word(32'hC4C5C6C7);
        push_word(32'hC8C9CACB);
        start_block(8);
        wait_valid("bp", 80, lat);
        hold = s_res;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0);
            check("bp_valid_held", s_valid, 1);
            check("bp_res_stable", s_res, hold);
        end
        check("bp_in_ready_low", s_ready, 0);
        ordy_v = 1'b1;
        cycle(1'b0);
        cycle(1'b0);
        check("bp_valid_drop", s_valid, 0);

        // Drain the remaining 112 bits exactly with a 7-bit block
        start_block(7);
        wait_valid("drain", 80, lat);

        // Starvation from an empty accumulator, input valid every other cycle
        feed_mode = 0;
        push_word(32'hA0A1A2A3);
        push_word(32'hB4B5B6B7);
        push_word(32'h08192A3B);
        push_word(32'h4C5D6E7F);
        start_block(8);
        feed_mode = 2;
        wait_valid("starve", 200, lat);
        check("starve_stalled", lat >= 18, 1);
        check("starve_vec", s_res, 128'h7F6E5D4C3B2A1908_B7B6B5B4A3A2A1A0);
        feed_mode = 1;

        // Illegal widths
        for (int t = 0; t < 2; t++) begin
            res_v = (t == 0) ? 4'd0 : 4'd9;
            cycle(1'b1);
            cycle(1'b0);
            check($sformatf("illegal%0d_err", t), s_err, 1);
            check($sformatf("illegal%0d_busy", t), s_busy, 0);
            cycle(1'b0);
            check($sformatf("illegal%0d_err_pulse", t), s_err, 0);
            check($sformatf("illegal%0d_no_valid", t), s_valid, 0);
        end
        push_word(32'h12345678);
        push_word(32'h9ABCDEF0);
        push_word(32'h0F1E2D3C);
        start_block(5);
        wait_valid("after_illegal", 80, lat);

        // Reset after the 7th extraction of a 4-bit block
        cycle(1'b0);
        push_word(32'h55555555);
        push_word(32'h66666666);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        start_block(4);
        for (int i = 0; i < 7; i++) cycle(1'b0);
        rst_v = 1'b1;
        tx_q.delete();
        bits_q.delete();
        exp_q.delete();
        cycle(1'b0);
        check("midrst_in_ready", s_ready, 0);
        cycle(1'b0);
        check("midrst_busy", s_busy, 0);
        check("midrst_valid", s_valid, 0);
        check("midrst_res", s_res, 0);
        rst_v = 1'b0;
        cycle(1'b0);
        check("midrst_in_ready_after", s_ready, 1);
        push_word(32'hA1B2C3D4);
        push_word(32'hE5F60718);
        start_block(4);
        wait_valid("post_rst", 60, lat);
        check("post_rst_vec", s_res, 128'hF8010700_06FF05FE_04FD03FC_02FB01FA);

        for (int i = 0; i < 4; i++) cycle(1'b0);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
